s27_bist_ctrl: RTL and testbench
================================

# s27_bist_ctrl

Built-in self-test controller for the s27 sequential core. It synchronizes the core's uninitialized state with a fixed vector, applies an LFSR pattern sequence to inputs a/b/c/d, and compacts output f into a 4-bit signature register. It reports pass/fail against a golden signature. It sits beside the core in the test wrapper and owns the core's primary inputs while busy.

## Interface
- PATTERNS, 15: number of LFSR patterns applied (1..15).
- SEED, 4'b0001: LFSR seed, nonzero.
- GOLDEN, 4'h0: expected signature; set per netlist at integration.
- clock  in  1  system clock; controller uses posedge, the core captures on negedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a test.
- core_f  in  1  core output f.
- core_abcd  out  4  core inputs {a,b,c,d}, registered.
- busy  out  1  test in progress.
- done  out  1  one-cycle pulse at test end.
- pass  out  1  signature matched and sync check passed; valid from done until the next start.
- sync_err  out  1  core failed the sync check; sticky until the next start.
- signature  out  4  current SISR contents.

## Operation
- Reset values: core_abcd=4'b1010 (the sync vector), busy=0, done=0, pass=0, sync_err=0, signature=0, state=IDLE.
- FSM states:
  - IDLE: start=1 goes to SYNC. Entry clears signature, pass and sync_err, and loads the LFSR with SEED.
  - SYNC, 2 cycles: core_abcd holds 4'b1010. With a=1, b=0, c=1, d=0, one negedge forces the core state to lo0=1, lo1=0, lo2=0 and f=1. At the last SYNC posedge, core_f==0 sets sync_err. Then go to RUN.
  - RUN, PATTERNS cycles: core_abcd=lfsr. The LFSR advances each cycle with next={l[2:0], l[3]^l[2]} (x^4+x^3+1).
  - FLUSH, 1 cycle: core_abcd returns to 4'b1010.
  - DONE, 1 cycle: done=1 and pass=(signature==GOLDEN)&&!sync_err. Then go to IDLE.
- Compaction:
  - Signature update: sig_next={sig[2:0], sig[3]^sig[2]^core_f}.
  - It is performed at each posedge that ends a RUN pattern. That is the first posedge of RUN+1 through the FLUSH-entry posedge, PATTERNS updates in total.
  - core_f is sampled just before core_abcd changes, so it reflects the negedge capture made under the same pattern.
- start while busy is ignored.
- busy=1 in SYNC, RUN and FLUSH.
- reset_n low mid-test aborts immediately: all outputs return to reset values and no done is pulsed.

## Timing
- start at posedge T gives busy=1 and SYNC from T+1.
- RUN spans T+3 .. T+2+PATTERNS.
- FLUSH is at T+3+PATTERNS, done at T+4+PATTERNS.
- Total latency from start to done is PATTERNS+4 cycles (19 at default).
- Pattern k (k=0..PATTERNS-1) is driven during cycle T+3+k and compacted at posedge T+4+k.
- pass and signature are stable from done until the next accepted start.
- start in the DONE cycle is ignored; start in the cycle after DONE (IDLE) is accepted.

## Structure
- Package s27_bist_pkg holds:
  - the state enum (IDLE, SYNC, RUN, FLUSH, DONE);
  - SYNC_VEC=4'b1010 and SYNC_CYCLES=2;
  - the LFSR tap constants.
- One sub-module, bist_lfsr4: a 4-bit shift register with load, enable and a serial-in XOR, so it can serve both as pattern generator (serial-in 0) and as SISR (serial-in core_f).
- The pattern counter and FSM stay in s27_bist_ctrl.

## Test plan
- Reset/idle: reset_n low, then high with no start → core_abcd=4'b1010, busy=0, done=0, signature=0, held for 20 cycles.
- Pattern sequence: default params with the real core attached → core_abcd in RUN is 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000; done lands exactly 19 cycles after start.
- Signature:
  - Set GOLDEN to the reference-model signature computed from the same stimulus → pass=1, sync_err=0.
  - GOLDEN equal to that value XOR 1 → pass=0.
  - Force core_f stuck-at-0 during RUN → signature differs and pass=0.
- Sync check: force core_f=0 during the last SYNC cycle → sync_err=1, and pass=0 at done even with a matching signature.
- Abort/restart: reset_n low at RUN cycle 5 → outputs at reset values with no done. A new start then gives a full 19-cycle run with an identical signature. start pulses while busy do not extend the run or change the result.
- PATTERNS=1, SEED=4'b1000: RUN lasts one cycle with core_abcd=1000, exactly one compaction occurs, and done comes 5 cycles after start.

Source files
------------

// File: rtl/s27_bist_pkg.sv
// s27_bist_pkg: shared types and constants for the s27 BIST controller
// Holds the controller state enum, the core synchronising vector and the
// tap positions of the x^4+x^3+1 shift register used for patterns and SISR.
package s27_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  // {a,b,c,d}=1010 forces the core to lo0=1, lo1=0, lo2=0 in one capture
  localparam logic [3:0] SYNC_VEC    = 4'b1010;
  localparam int         SYNC_CYCLES = 2;

  // feedback bit = l[TAP_HI] ^ l[TAP_LO] (x^4 + x^3 + 1)
  localparam int TAP_HI = 3;
  localparam int TAP_LO = 2;

endpackage

// File: rtl/bist_lfsr4.sv
// bist_lfsr4: 4-bit shift register with load, enable and serial-in xor
// Ports:
//   clock, reset_n : posedge clock, asynchronous active-low reset to RST_VAL
//   load, load_val : synchronous load (wins over en)
//   en             : shift one step: q <= {q[2:0], q[3]^q[2]^sin}
//   sin            : serial input folded into the feedback (0 = plain LFSR)
//   q              : register contents
module bist_lfsr4
  import s27_bist_pkg::*;
#(
  parameter logic [3:0] RST_VAL = 4'h0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  input  logic       sin,
  output logic [3:0] q
);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = load ? load_val
        : en   ? {q_q[2:0], q_q[TAP_HI] ^ q_q[TAP_LO] ^ sin}
        : q_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) q_q <= RST_VAL;
    else          q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/s27_bist_ctrl.sv
// s27_bist_ctrl: BIST controller that syncs, stimulates and signs the s27 core
// Ports:
//   clock     : controller uses posedge; the core captures on negedge
//   reset_n   : asynchronous active-low reset, aborts a test in flight
//   start     : one-cycle request, accepted only in IDLE
//   core_f    : core output f
//   core_abcd : registered core inputs {a,b,c,d}
//   busy      : high in SYNC, RUN and FLUSH
//   done      : one-cycle pulse at the end of a test
//   pass      : signature matched GOLDEN and sync check passed
//   sync_err  : core did not reach f=1 after synchronisation (sticky)
//   signature : current SISR contents
module s27_bist_ctrl
  import s27_bist_pkg::*;
#(
  parameter int         PATTERNS = 15,
  parameter logic [3:0] SEED     = 4'b0001,
  parameter logic [3:0] GOLDEN   = 4'h0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       core_f,
  output logic [3:0] core_abcd,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       sync_err,
  output logic [3:0] signature
);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] abcd_q, abcd_d;
  logic       pass_q, pass_d;
  logic       sync_err_q, sync_err_d;
  logic [3:0] lfsr;
  logic [3:0] sig;
  logic       go;
  logic       sync_last;
  logic       run_last;

  assign go        = (state_q == IDLE) && start;
  assign sync_last = (cnt_q == 4'(SYNC_CYCLES - 1));
  assign run_last  = (cnt_q == 4'(PATTERNS - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? SYNC : IDLE;
      SYNC:    state_d = sync_last ? RUN : SYNC;
      RUN:     state_d = run_last ? FLUSH : RUN;
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cnt restarts on every state change, so it measures time spent in a state
  always_comb begin
    cnt_d      = (state_d != state_q) ? 4'd0 : cnt_q + 4'd1;
    // the pattern generator already holds the next pattern, so registering
    // it here lines the pattern up with the RUN cycle that presents it
    abcd_d     = (state_d == RUN) ? lfsr : SYNC_VEC;
    sync_err_d = go ? 1'b0
               : (state_q == SYNC && sync_last && !core_f) ? 1'b1
               : sync_err_q;
    // the last compaction lands on the FLUSH-entry edge, so sig is final here
    pass_d     = go ? 1'b0
               : (state_q == FLUSH) ? ((sig == GOLDEN) && !sync_err_q)
               : pass_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      abcd_q     <= SYNC_VEC;
      pass_q     <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      abcd_q     <= abcd_d;
      pass_q     <= pass_d;
      sync_err_q <= sync_err_d;
    end
  end

  bist_lfsr4 #(.RST_VAL(SEED)) u_pattern (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (go),
    .load_val (SEED),
    .en       (state_d == RUN),
    .sin      (1'b0),
    .q        (lfsr)
  );

  // core_f is taken on the edge that ends each RUN cycle, i.e. after the
  // negedge capture made under that same pattern
  bist_lfsr4 #(.RST_VAL(4'h0)) u_sisr (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (go),
    .load_val (4'h0),
    .en       (state_q == RUN),
    .sin      (core_f),
    .q        (sig)
  );

  assign core_abcd = abcd_q;
  assign busy      = (state_q == SYNC) || (state_q == RUN) || (state_q == FLUSH);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign sync_err  = sync_err_q;
  assign signature = sig;

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// tb_s27_bist_ctrl: self-checking bench for s27_bist_ctrl with behavioural s27 cores
module tb_s27_bist_ctrl;

  localparam logic [3:0] GOLD0 = 4'hF;
  localparam logic [3:0] GOLD1 = 4'hE;

  logic clock;
  logic reset_n;
  logic start0, start2;
  logic f_ovr;
  int   n_chk, n_fail;

  logic [3:0] abcd0, abcd1, abcd2, sig0, sig1, sig2;
  logic busy0, busy1, busy2, done0, done1, done2;
  logic pass0, pass1, pass2, serr0, serr1, serr2;
  logic f0, f1, f2;

  logic [2:0] cs0 = 3'($urandom);
  logic [2:0] cs1 = 3'($urandom);
  logic [2:0] cs2 = 3'($urandom);
  logic [3:0] ev0, ev1, ev2;

  logic [3:0] obs_abcd [0:63];
  logic       obs_busy [0:63];
  logic [3:0] exp_pat  [0:14] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                                  4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                                  4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

  // s27 gate netlist; s = {lo0,lo1,lo2}, in = {a,b,c,d}; returns {next_s, f}
  function automatic logic [3:0] core_eval(input logic [2:0] s, input logic [3:0] in);
    logic g5, g6, g7, g8, g9, g10, g11, g12, g13, g14, g15, g16;
    g5 = s[2]; g6 = s[1]; g7 = s[0];
    g14 = ~in[3];
    g8  = g14 & g6;
    g12 = ~(in[2] | g7);
    g15 = g12 | g8;
    g16 = in[0] | g8;
    g9  = ~(g16 & g15);
    g11 = ~(g5 | g9);
    g10 = ~(g14 | g11);
    g13 = ~(in[1] | g12);
    return {g10, g11, g13, ~g11};
  endfunction

  // expected signature: core starts synced, each pattern is captured, then f is compacted
  function automatic logic [3:0] ref_sig(input int n, input logic [3:0] seed, input bit stuck);
    logic [2:0] s = 3'b100;
    logic [3:0] l = seed;
    logic [3:0] sg = 4'h0;
    logic [3:0] e;
    logic f;
    for (int k = 0; k < n; k++) begin
      e = core_eval(s, l);
      s = e[3:1];
      e = core_eval(s, l);
      f = stuck ? 1'b0 : e[0];
      sg = {sg[2:0], sg[3] ^ sg[2] ^ f};
      l = {l[2:0], l[3] ^ l[2]};
    end
    return sg;
  endfunction

  assign ev0 = core_eval(cs0, abcd0);
  assign ev1 = core_eval(cs1, abcd1);
  assign ev2 = core_eval(cs2, abcd2);
  assign f0  = f_ovr ? 1'b0 : ev0[0];
  assign f1  = ev1[0];
  assign f2  = ev2[0];

  always @(negedge clock) begin
    cs0 <= ev0[3:1];
    cs1 <= ev1[3:1];
    cs2 <= ev2[3:1];
  end

  s27_bist_ctrl #(.PATTERNS(15), .SEED(4'b0001), .GOLDEN(GOLD0)) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start0), .core_f(f0),
    .core_abcd(abcd0), .busy(busy0), .done(done0), .pass(pass0),
    .sync_err(serr0), .signature(sig0));

  s27_bist_ctrl #(.PATTERNS(15), .SEED(4'b0001), .GOLDEN(GOLD1)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start0), .core_f(f1),
    .core_abcd(abcd1), .busy(busy1), .done(done1), .pass(pass1),
    .sync_err(serr1), .signature(sig1));

  s27_bist_ctrl #(.PATTERNS(1), .SEED(4'b1000), .GOLDEN(4'h0)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start2), .core_f(f2),
    .core_abcd(abcd2), .busy(busy2), .done(done2), .pass(pass2),
    .sync_err(serr2), .signature(sig2));

  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 2) start2 = v;
    else start0 = v;
  endtask

  // drives one test; dc = cycles from the accepting edge to done, -1 if it never came
  task automatic drive_run(input int sel, input int olo, input int ohi,
                           input bit noise, input bit pre, output int dc);
    int p;
    p = (sel == 2) ? 1 : 15;
    dc = -1;
    if (!pre) begin
      set_start(sel, 1'b1);
      step;
    end
    for (int c = 1; c <= 40; c++) begin
      obs_abcd[c] = (sel == 2) ? abcd2 : abcd0;
      obs_busy[c] = (sel == 2) ? busy2 : busy0;
      if (((sel == 2) ? done2 : done0) === 1'b1) begin
        dc = c;
        break;
      end
      f_ovr = (c >= olo) && (c <= ohi);
      set_start(sel, noise && (c <= 3 + p) && ($urandom_range(0, 2) == 0));
      step;
    end
    f_ovr = 1'b0;
    set_start(sel, 1'b0);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) step;
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step;
      n_chk++;
      if ({abcd0, busy0, done0, sig0, pass0, serr0} !== {4'b1010, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: abcd=%b busy=%b done=%b sig=%h pass=%b serr=%b, want abcd=1010 others 0",
                 i, abcd0, busy0, done0, sig0, pass0, serr0);
      end
    end
  endtask

  task automatic test_patterns;
    int dc;
    logic [3:0] r;
    logic [3:0] want;
    r = ref_sig(15, 4'b0001, 1'b0);
    repeat ($urandom_range(1, 4)) step;
    drive_run(0, 0, -1, 1'b0, 1'b0, dc);
    n_chk++;
    if (dc !== 19) begin
      n_fail++;
      $display("FAIL pat_latency: done at %0d, want 19", dc);
    end
    for (int c = 1; c <= 18; c++) begin
      want = (c >= 3 && c <= 17) ? exp_pat[c-3] : 4'b1010;
      n_chk++;
      if (obs_abcd[c] !== want || obs_busy[c] !== 1'b1) begin
        n_fail++;
        $display("FAIL pat_seq cycle %0d: abcd=%b busy=%b, want abcd=%b busy=1", c, obs_abcd[c], obs_busy[c], want);
      end
    end
    n_chk++;
    if (sig0 !== r || pass0 !== (r == GOLD0) || serr0 !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL pat_result: sig=%h pass=%b serr=%b busy=%b, want sig=%h pass=%b serr=0 busy=0",
               sig0, pass0, serr0, busy0, r, r == GOLD0);
    end
    n_chk++;
    if (sig1 !== r || pass1 !== (r == GOLD1) || done1 !== 1'b1) begin
      n_fail++;
      $display("FAIL golden_xor1: sig=%h pass=%b done=%b, want sig=%h pass=%b done=1", sig1, pass1, done1, r, r == GOLD1);
    end
  endtask

  task automatic test_start_noise;
    int dc;
    logic [3:0] r;
    r = ref_sig(15, 4'b0001, 1'b0);
    for (int n = 0; n < 3; n++) begin
      repeat ($urandom_range(1, 6)) step;
      drive_run(0, 0, -1, 1'b1, 1'b0, dc);
      n_chk++;
      if (dc !== 19 || sig0 !== r || pass0 !== (r == GOLD0) || pass1 !== (r == GOLD1)) begin
        n_fail++;
        $display("FAIL start_noise run %0d: done at %0d sig=%h pass=%b pass1=%b, want 19 sig=%h pass=%b pass1=%b",
                 n, dc, sig0, pass0, pass1, r, r == GOLD0, r == GOLD1);
      end
    end
  endtask

  task automatic test_stuck;
    int dc;
    logic [3:0] rs;
    logic [3:0] r;
    rs = ref_sig(15, 4'b0001, 1'b1);
    r  = ref_sig(15, 4'b0001, 1'b0);
    repeat ($urandom_range(1, 4)) step;
    drive_run(0, 3, 17, 1'b0, 1'b0, dc);
    n_chk++;
    if (dc !== 19 || sig0 !== rs || sig0 === r || pass0 !== (rs == GOLD0)) begin
      n_fail++;
      $display("FAIL stuck_f0: done at %0d sig=%h pass=%b, want 19 sig=%h (not %h) pass=%b",
               dc, sig0, pass0, rs, r, rs == GOLD0);
    end
  endtask

  task automatic test_sync_err;
    int dc;
    logic [3:0] r;
    r = ref_sig(15, 4'b0001, 1'b0);
    repeat ($urandom_range(1, 4)) step;
    drive_run(0, 2, 2, 1'b0, 1'b0, dc);
    n_chk++;
    if (dc !== 19 || serr0 !== 1'b1 || pass0 !== 1'b0 || sig0 !== r) begin
      n_fail++;
      $display("FAIL sync_err: done at %0d serr=%b pass=%b sig=%h, want 19 serr=1 pass=0 sig=%h", dc, serr0, pass0, sig0, r);
    end
    step;
    n_chk++;
    if (serr0 !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_err_sticky: serr=%b, want 1", serr0);
    end
  endtask

  task automatic test_abort;
    int dc;
    logic [3:0] r;
    r = ref_sig(15, 4'b0001, 1'b0);
    repeat ($urandom_range(1, 4)) step;
    start0 = 1'b1;
    step;
    start0 = 1'b0;
    n_chk++;
    if (serr0 !== 1'b0 || busy0 !== 1'b1 || sig0 !== 4'h0) begin
      n_fail++;
      $display("FAIL start_clears: serr=%b busy=%b sig=%h, want serr=0 busy=1 sig=0", serr0, busy0, sig0);
    end
    repeat (7) step;
    n_chk++;
    if (abcd0 !== exp_pat[5]) begin
      n_fail++;
      $display("FAIL abort_pre: abcd=%b, want %b", abcd0, exp_pat[5]);
    end
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({abcd0, busy0, done0, sig0, pass0, serr0} !== {4'b1010, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_reset: abcd=%b busy=%b done=%b sig=%h pass=%b serr=%b, want 1010 and zeros",
               abcd0, busy0, done0, sig0, pass0, serr0);
    end
    for (int i = 0; i < 14; i++) begin
      if (i == 3) reset_n = 1'b1;
      step;
      n_chk++;
      if (done0 !== 1'b0 || busy0 !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_done cycle %0d: done=%b busy=%b, want 0 0", i, done0, busy0);
      end
    end
    drive_run(0, 0, -1, 1'b0, 1'b0, dc);
    n_chk++;
    if (dc !== 19 || sig0 !== r || pass0 !== (r == GOLD0)) begin
      n_fail++;
      $display("FAIL abort_restart: done at %0d sig=%h pass=%b, want 19 sig=%h pass=%b", dc, sig0, pass0, r, r == GOLD0);
    end
  endtask

  task automatic test_back_to_back;
    int dc;
    logic [3:0] r;
    logic ps;
    logic [3:0] ss;
    r = ref_sig(15, 4'b0001, 1'b0);
    repeat ($urandom_range(1, 4)) step;
    drive_run(0, 0, -1, 1'b0, 1'b0, dc);
    ps = pass0;
    ss = sig0;
    start0 = 1'b1;
    step;
    n_chk++;
    if (busy0 !== 1'b0 || pass0 !== ps || sig0 !== ss || pass0 !== (r == GOLD0)) begin
      n_fail++;
      $display("FAIL start_in_done: busy=%b pass=%b sig=%h, want busy=0 pass=%b sig=%h", busy0, pass0, sig0, r == GOLD0, ss);
    end
    step;
    n_chk++;
    if (busy0 !== 1'b1 || pass0 !== 1'b0 || sig0 !== 4'h0) begin
      n_fail++;
      $display("FAIL start_after_done: busy=%b pass=%b sig=%h, want busy=1 pass=0 sig=0", busy0, pass0, sig0);
    end
    drive_run(0, 0, -1, 1'b0, 1'b1, dc);
    n_chk++;
    if (dc !== 19 || sig0 !== r) begin
      n_fail++;
      $display("FAIL back_to_back: done at %0d sig=%h, want 19 sig=%h", dc, sig0, r);
    end
  endtask

  task automatic test_short;
    int dc;
    logic [3:0] r;
    r = ref_sig(1, 4'b1000, 1'b0);
    repeat ($urandom_range(1, 4)) step;
    drive_run(2, 0, -1, 1'b0, 1'b0, dc);
    n_chk++;
    if (dc !== 5) begin
      n_fail++;
      $display("FAIL short_latency: done at %0d, want 5", dc);
    end
    n_chk++;
    if (obs_abcd[2] !== 4'b1010 || obs_abcd[3] !== 4'b1000 || obs_abcd[4] !== 4'b1010) begin
      n_fail++;
      $display("FAIL short_seq: abcd c2..c4 = %b %b %b, want 1010 1000 1010", obs_abcd[2], obs_abcd[3], obs_abcd[4]);
    end
    n_chk++;
    if (sig2 !== r || pass2 !== (r == 4'h0)) begin
      n_fail++;
      $display("FAIL short_sig: sig=%h pass=%b, want sig=%h pass=%b", sig2, pass2, r, r == 4'h0);
    end
  endtask

  initial begin
    clock   = 1'b0;
    reset_n = 1'b0;
    start0  = 1'b0;
    start2  = 1'b0;
    f_ovr   = 1'b0;
    n_chk   = 0;
    n_fail  = 0;
    test_reset;
    test_patterns;
    test_start_noise;
    test_stuck;
    test_sync_err;
    test_abort;
    test_back_to_back;
    test_short;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
